// File: rtl/branch_resolve_ctrl.sv
// ID-stage branch resolution: operand-wait stall, Mealy condition evaluation,
// a single redirect per branch, saturating statistics and a sticky wait watchdog.
module branch_resolve_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic             id_flush,
   input  logic [4:0]       id_alucode,
   input  logic [31:0]      id_pc,
   input  logic [31:0]      id_imm,
   input  logic [31:0]      rs_data,
   input  logic [31:0]      rt_data,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic             stall_in,
   output logic             stall_id,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush_if,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] taken_cnt,
   output logic             wait_err
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               wait_err_q, wait_err_d;
   logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]   taken_cnt_q, taken_cnt_d;

   logic is_br, two_op, br, ready, taken, resolve, stall;
   logic rs_eq, rs_zero, rs_neg;

   always_comb begin
      is_br  = (id_alucode >= 5'b01010) && (id_alucode <= 5'b01111);
      two_op = (id_alucode == 5'b01010) || (id_alucode == 5'b01011);
   end

   assign br      = id_valid & ~id_flush & is_br;
   assign ready   = rs_ready & (rt_ready | ~two_op);
   assign rs_eq   = (rs_data == rt_data);
   assign rs_zero = (rs_data == 32'd0);
   assign rs_neg  = rs_data[31];

   always_comb begin
      taken = 1'b0;
      case (id_alucode)
         5'b01010: taken = rs_eq;
         5'b01011: taken = ~rs_eq;
         5'b01100: taken = ~rs_neg;
         5'b01101: taken = ~rs_neg & ~rs_zero;
         5'b01110: taken = rs_neg | rs_zero;
         5'b01111: taken = rs_neg;
         default:  taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      wait_err_d = wait_err_q;
      stall      = 1'b0;
      resolve    = 1'b0;
      case (state_q)
         IDLE: begin
            if (br && !ready) begin
               stall      = 1'b1;
               state_d    = WAIT;
               wait_cnt_d = '0;
            end else if (br) begin
               resolve = 1'b1;
               if (stall_in) state_d = HOLD;
            end
         end
         WAIT: begin
            if (!br) begin
               state_d = IDLE;
            end else if (ready) begin
               resolve = 1'b1;
               state_d = stall_in ? HOLD : IDLE;
            end else begin
               stall = 1'b1;
               if (wait_cnt_q < WAIT_LIM) wait_cnt_d = wait_cnt_q + 1'b1;
               // err sets on the edge where wait_cnt becomes MAX_WAIT
               if (wait_cnt_q >= WAIT_LIM - 1'b1) wait_err_d = 1'b1;
            end
         end
         HOLD: begin
            if (!stall_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (id_flush) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end
   end

   always_comb begin
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (resolve) begin
         if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + 1'b1;
         if (taken && taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_cnt_q   <= '0;
         wait_err_q   <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         wait_err_q   <= wait_err_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   // Mealy outputs are gated by rst_n so they drop the instant reset asserts.
   assign stall_id       = stall & rst_n;
   assign redirect_valid = resolve & taken & rst_n;
   assign flush_if       = resolve & taken & rst_n;
   assign redirect_pc    = id_pc + 32'd4 + {id_imm[29:0], 2'b00};
   assign branch_cnt     = branch_cnt_q;
   assign taken_cnt      = taken_cnt_q;
   assign wait_err       = wait_err_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with MAX_WAIT=2; expected values are hand-computed.
module tb_branch_resolve_ctrl;
   localparam int CNT_W = 16;

   logic clk = 1'b0, rst_n = 1'b0;
   logic id_valid, id_flush, rs_ready, rt_ready, stall_in;
   logic [4:0]  id_alucode;
   logic [31:0] id_pc, id_imm, rs_data, rt_data;
   logic stall_id, redirect_valid, flush_if, wait_err;
   logic [31:0] redirect_pc;
   logic [CNT_W-1:0] branch_cnt, taken_cnt;

   int total = 0, passed = 0;
   int stall_cycles, pulses;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(2)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
      .id_alucode(id_alucode), .id_pc(id_pc), .id_imm(id_imm),
      .rs_data(rs_data), .rt_data(rt_data), .rs_ready(rs_ready), .rt_ready(rt_ready),
      .stall_in(stall_in), .stall_id(stall_id), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .flush_if(flush_if), .branch_cnt(branch_cnt),
      .taken_cnt(taken_cnt), .wait_err(wait_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic drv(input logic v, input logic [4:0] code, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs, input logic [31:0] rt,
                      input logic rsr, input logic rtr, input logic st);
      id_valid = v; id_flush = 1'b0; id_alucode = code; id_pc = pc; id_imm = imm;
      rs_data = rs; rt_data = rt; rs_ready = rsr; rt_ready = rtr; stall_in = st;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset: a ready taken beq is presented but outputs must stay 0
      drv(1, 5'b01010, 32'h0040_0000, 32'h3, 32'h1234, 32'h1234, 1, 1, 0);
      chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rst_flush", {31'd0, flush_if}, 32'd0);
      chk("rst_stall", {31'd0, stall_id}, 32'd0);
      chk("rst_bcnt", {16'd0, branch_cnt}, 32'd0);
      chk("rst_tcnt", {16'd0, taken_cnt}, 32'd0);
      chk("rst_werr", {31'd0, wait_err}, 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;

      // taken beq, same-cycle redirect
      chk("beq_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("beq_flush", {31'd0, flush_if}, 32'd1);
      chk("beq_pc", redirect_pc, 32'h0040_0010);
      chk("beq_stall", {31'd0, stall_id}, 32'd0);
      tick();
      chk("beq_bcnt", {16'd0, branch_cnt}, 32'd1);
      chk("beq_tcnt", {16'd0, taken_cnt}, 32'd1);

      // bgtz rs=0 not taken
      drv(1, 5'b01101, 32'h100, 32'h4, 32'h0, 32'h5, 1, 0, 0);
      chk("bgtz_redirect", {31'd0, redirect_valid}, 32'd0);
      tick();
      chk("bgtz_bcnt", {16'd0, branch_cnt}, 32'd2);
      chk("bgtz_tcnt", {16'd0, taken_cnt}, 32'd1);

      // blez rs=0 taken, negative offset
      drv(1, 5'b01110, 32'h100, 32'hFFFF_FFFE, 32'h0, 32'h5, 1, 0, 0);
      chk("blez_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("blez_pc", redirect_pc, 32'h0000_00FC);
      tick();
      chk("blez_bcnt", {16'd0, branch_cnt}, 32'd3);
      chk("blez_tcnt", {16'd0, taken_cnt}, 32'd2);

      // bne waiting 3 cycles on rt; watchdog limit 2
      stall_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         drv(1, 5'b01011, 32'h200, 32'h10, 32'h1, 32'h2, 1, 0, 0);
         if (stall_id) stall_cycles++;
         chk("bne_wait_noredir", {31'd0, redirect_valid}, 32'd0);
         if (i < 2) chk("bne_werr_early", {31'd0, wait_err}, 32'd0);
         tick();
      end
      drv(1, 5'b01011, 32'h200, 32'h10, 32'h1, 32'h2, 1, 1, 0);
      if (stall_id) stall_cycles++;
      chk("bne_stall_cycles", stall_cycles, 32'd3);
      chk("bne_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("bne_pc", redirect_pc, 32'h0000_0244);
      chk("bne_werr", {31'd0, wait_err}, 32'd1);
      tick();
      chk("bne_bcnt", {16'd0, branch_cnt}, 32'd4);
      chk("bne_tcnt", {16'd0, taken_cnt}, 32'd3);
      drv(0, 5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
      tick();
      chk("werr_sticky", {31'd0, wait_err}, 32'd1);

      // taken beq held 4 cycles by stall_in, then one more cycle as stall drops
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         drv(1, 5'b01010, 32'h300, 32'h1, 32'h7, 32'h7, 1, 1, (i < 4));
         if (redirect_valid) pulses++;
         chk("hold_stall", {31'd0, stall_id}, 32'd0);
         tick();
      end
      chk("hold_pulses", pulses, 32'd1);
      chk("hold_bcnt", {16'd0, branch_cnt}, 32'd5);
      chk("hold_tcnt", {16'd0, taken_cnt}, 32'd4);
      // back in IDLE: a new branch resolves immediately
      drv(1, 5'b01100, 32'hFFFF_FFF8, 32'h1, 32'h0, 32'h0, 1, 0, 0);
      chk("wrap_redirect", {31'd0, redirect_valid}, 32'd1);
      chk("wrap_pc", redirect_pc, 32'h0000_0000);
      tick();
      chk("wrap_bcnt", {16'd0, branch_cnt}, 32'd6);
      chk("wrap_tcnt", {16'd0, taken_cnt}, 32'd5);

      // flush during WAIT
      drv(1, 5'b01111, 32'h400, 32'h2, 32'h8000_0000, 32'h0, 0, 0, 0);
      chk("fl_stall0", {31'd0, stall_id}, 32'd1);
      tick();
      drv(1, 5'b01111, 32'h400, 32'h2, 32'h8000_0000, 32'h0, 1, 0, 0);
      id_flush = 1'b1;
      #1;
      chk("fl_stall1", {31'd0, stall_id}, 32'd0);
      chk("fl_redirect", {31'd0, redirect_valid}, 32'd0);
      tick();
      drv(0, 5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1, 0);
      tick();
      chk("fl_bcnt", {16'd0, branch_cnt}, 32'd6);
      chk("fl_tcnt", {16'd0, taken_cnt}, 32'd5);

      // preload to 0xFFFE with not-taken bne, then 3 taken beq
      drv(1, 5'b01011, 32'h0, 32'h0, 32'h9, 32'h9, 1, 1, 0);
      for (int i = 0; i < 32'hFFFE - 6; i++) tick();
      chk("sat_pre", {16'd0, branch_cnt}, 32'h0000_FFFE);
      drv(1, 5'b01010, 32'h0, 32'h0, 32'h9, 32'h9, 1, 1, 0);
      tick(); tick(); tick();
      chk("sat_bcnt", {16'd0, branch_cnt}, 32'h0000_FFFF);
      chk("sat_tcnt", {16'd0, taken_cnt}, 32'd8);

      // asynchronous reset mid-WAIT
      drv(1, 5'b01010, 32'h500, 32'h1, 32'h1, 32'h1, 1, 0, 0);
      tick();
      chk("rw_stall", {31'd0, stall_id}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_stall0", {31'd0, stall_id}, 32'd0);
      chk("rw_redirect", {31'd0, redirect_valid}, 32'd0);
      chk("rw_flush", {31'd0, flush_if}, 32'd0);
      chk("rw_bcnt", {16'd0, branch_cnt}, 32'd0);
      chk("rw_tcnt", {16'd0, taken_cnt}, 32'd0);
      chk("rw_werr", {31'd0, wait_err}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
